// File: rtl/tag_free_list_mp_pkg.sv
// tag_free_list_mp_pkg
//   Shared types and helpers for the multi-port tag free list.
//   - Default configuration constants (tag width, release ports, low-water level).
//   - tag_t / count_t for the default configuration.
//   - prefix_count(): number of set mask bits below a given port index. It is
//     used to place accepted releases at consecutive list slots.
package tag_free_list_mp_pkg;

    localparam int DEF_TAG_BITS  = 3;
    localparam int DEF_NUM_REL   = 2;
    localparam int DEF_LOW_WATER = 2;

    // Widest release mask the helper understands.
    localparam int MAX_REL = 4;

    // A count runs 0..N, so it needs one bit more than a tag.
    localparam int DEF_CNT_BITS = DEF_TAG_BITS + 1;

    typedef logic [DEF_TAG_BITS-1:0] tag_t;
    typedef logic [DEF_CNT_BITS-1:0] count_t;

    // Count of set bits in mask[k-1:0]. prefix_count(mask, MAX_REL) is the
    // total number of set bits.
    function automatic int unsigned prefix_count(input logic [MAX_REL-1:0] mask,
                                                 input int unsigned k);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MAX_REL; i++) begin
            if ((i < k) && mask[i]) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/tag_free_list_mp_if.sv
// tag_free_list_mp_if
//   Bundle between the tag consumers/producers (master) and the free list
//   (slave).
//   master drives : enable, flush, alloc_req, rel_valid, rel_tag
//   slave drives  : alloc_valid, alloc_tag, free_count, low_water, err_double_free
//
// Handshake: alloc_valid is the offer and alloc_req the take; a tag transfers
// in every cycle where enable && alloc_valid && alloc_req, and the tag moved is
// the alloc_tag shown in that same cycle. Releases have no back-pressure: each
// rel_valid[k] is a one-cycle strobe, either accepted or dropped with
// err_double_free raised in the following cycle.
interface tag_free_list_mp_if
    import tag_free_list_mp_pkg::*;
#(
    parameter int TAG_BITS = DEF_TAG_BITS,
    parameter int NUM_REL  = DEF_NUM_REL
) ();

    logic                        enable;
    logic                        flush;
    logic                        alloc_req;
    logic                        alloc_valid;
    logic [TAG_BITS-1:0]         alloc_tag;
    logic [NUM_REL-1:0]          rel_valid;
    logic [NUM_REL*TAG_BITS-1:0] rel_tag;
    logic [TAG_BITS:0]           free_count;
    logic                        low_water;
    logic                        err_double_free;

    modport master (
        output enable, flush, alloc_req, rel_valid, rel_tag,
        input  alloc_valid, alloc_tag, free_count, low_water, err_double_free
    );

    modport slave (
        input  enable, flush, alloc_req, rel_valid, rel_tag,
        output alloc_valid, alloc_tag, free_count, low_water, err_double_free
    );

endinterface

// File: rtl/tag_free_list_mp_tag_release_arbiter.sv
// tag_release_arbiter
//   Combinational accept logic for the release ports.
//   Inputs : enable, rel_valid[NUM_REL], rel_tag (port k at [k*TAG_BITS +: TAG_BITS]),
//            in_list bitmap (bit t set = tag t currently free)
//   Outputs: accept[NUM_REL]    port k release is taken this cycle
//            offset             per-port slot offset from tail (same packing as rel_tag)
//            accept_count       number of accepted releases
//            reject_any         some valid release was dropped
module tag_release_arbiter
    import tag_free_list_mp_pkg::*;
#(
    parameter int TAG_BITS = DEF_TAG_BITS,
    parameter int NUM_REL  = DEF_NUM_REL
) (
    input  logic                        enable,
    input  logic [NUM_REL-1:0]          rel_valid,
    input  logic [NUM_REL*TAG_BITS-1:0] rel_tag,
    input  logic [(1<<TAG_BITS)-1:0]    in_list,
    output logic [NUM_REL-1:0]          accept,
    output logic [NUM_REL*TAG_BITS-1:0] offset,
    output logic [TAG_BITS:0]           accept_count,
    output logic                        reject_any
);

    logic [MAX_REL-1:0] mask_ext;

    // Port order matters: a tag offered on two ports is taken by the lower
    // one only, so the bitmap never gets the same tag inserted twice.
    always_comb begin
        accept     = '0;
        reject_any = 1'b0;
        for (int k = 0; k < NUM_REL; k++) begin
            logic ok;
            ok = enable && rel_valid[k] && !in_list[rel_tag[k*TAG_BITS +: TAG_BITS]];
            for (int j = 0; j < k; j++) begin
                if (accept[j] &&
                    (rel_tag[j*TAG_BITS +: TAG_BITS] == rel_tag[k*TAG_BITS +: TAG_BITS])) begin
                    ok = 1'b0;
                end
            end
            accept[k] = ok;
            if (enable && rel_valid[k] && !ok) begin
                reject_any = 1'b1;
            end
        end
    end

    assign mask_ext = MAX_REL'(accept);

    always_comb begin
        offset = '0;
        for (int unsigned k = 0; k < NUM_REL; k++) begin
            offset[k*TAG_BITS +: TAG_BITS] = TAG_BITS'(prefix_count(mask_ext, k));
        end
        accept_count = (TAG_BITS+1)'(prefix_count(mask_ext, MAX_REL));
    end

endmodule

// File: rtl/tag_free_list_mp.sv
// tag_free_list_mp
//   Circular FIFO of free cache tags with one allocate port and NUM_REL
//   release ports, a membership bitmap that rejects double-frees, an exact
//   free count, a registered low-water flag and a synchronous flush.
//   Ports:
//     clk, reset  clock and synchronous active-high reset
//     bus         tag_free_list_mp_if.slave (enable, flush, alloc_req,
//                 alloc_valid, alloc_tag, rel_valid, rel_tag, free_count,
//                 low_water, err_double_free)
module tag_free_list_mp
    import tag_free_list_mp_pkg::*;
#(
    parameter int TAG_BITS  = DEF_TAG_BITS,
    parameter int NUM_REL   = DEF_NUM_REL,
    parameter int LOW_WATER = DEF_LOW_WATER
) (
    input logic               clk,
    input logic               reset,
    tag_free_list_mp_if.slave bus
);

    localparam int N        = 1 << TAG_BITS;
    localparam int CNT_BITS = TAG_BITS + 1;

    logic [TAG_BITS-1:0] list_q [N];
    logic [N-1:0]        in_list_q;
    logic [TAG_BITS-1:0] head_q;
    logic [TAG_BITS-1:0] tail_q;
    logic [CNT_BITS-1:0] free_count_q;
    logic                low_water_q;
    logic                err_q;

    logic                        alloc_fire;
    logic [NUM_REL-1:0]          rel_accept;
    logic [NUM_REL*TAG_BITS-1:0] rel_offset;
    logic [CNT_BITS-1:0]         rel_count;
    logic                        rel_reject;
    logic [TAG_BITS-1:0]         wr_idx [NUM_REL];
    logic [CNT_BITS-1:0]         count_next;

    tag_release_arbiter #(
        .TAG_BITS (TAG_BITS),
        .NUM_REL  (NUM_REL)
    ) u_arb (
        .enable       (bus.enable),
        .rel_valid    (bus.rel_valid),
        .rel_tag      (bus.rel_tag),
        .in_list      (in_list_q),
        .accept       (rel_accept),
        .offset       (rel_offset),
        .accept_count (rel_count),
        .reject_any   (rel_reject)
    );

    assign alloc_fire = bus.enable && bus.alloc_req && (free_count_q != '0);

    // Slot for each release; the TAG_BITS-wide sum wraps round the ring.
    always_comb begin
        for (int k = 0; k < NUM_REL; k++) begin
            wr_idx[k] = tail_q + rel_offset[k*TAG_BITS +: TAG_BITS];
        end
    end

    // The bitmap keeps the result inside 0..N, so no saturation is needed.
    assign count_next = free_count_q - CNT_BITS'(alloc_fire) + rel_count;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int i = 0; i < N; i++) begin
                list_q[i] <= TAG_BITS'(i);
            end
            in_list_q    <= '1;
            head_q       <= '0;
            tail_q       <= '0;
            free_count_q <= CNT_BITS'(N);
            low_water_q  <= (N <= LOW_WATER);
            err_q        <= 1'b0;
        end else if (bus.enable) begin
            // A tag allocated this cycle still reads as free in the bitmap,
            // so it can never also be an accepted release; clear then set
            // cannot collide on the same bit.
            if (alloc_fire) begin
                in_list_q[list_q[head_q]] <= 1'b0;
                head_q                    <= head_q + 1'b1;
            end
            for (int k = 0; k < NUM_REL; k++) begin
                if (rel_accept[k]) begin
                    list_q[wr_idx[k]]                            <= bus.rel_tag[k*TAG_BITS +: TAG_BITS];
                    in_list_q[bus.rel_tag[k*TAG_BITS +: TAG_BITS]] <= 1'b1;
                end
            end
            tail_q       <= tail_q + TAG_BITS'(rel_count);
            free_count_q <= count_next;
            low_water_q  <= (count_next <= CNT_BITS'(LOW_WATER));
            err_q        <= rel_reject;
        end
    end

    assign bus.alloc_valid     = (free_count_q != '0);
    assign bus.alloc_tag       = list_q[head_q];
    assign bus.free_count      = free_count_q;
    assign bus.low_water       = low_water_q;
    assign bus.err_double_free = err_q;

endmodule

// File: tb/tb_tag_free_list_mp.sv
// tb_tag_free_list_mp
//   Directed bench for tag_free_list_mp with TAG_BITS=3, NUM_REL=2,
//   LOW_WATER=2. Inputs change 1 time unit after a rising edge and outputs
//   are sampled at that same point, well away from the next edge.
module tb_tag_free_list_mp;
    import tag_free_list_mp_pkg::*;

    logic clk;
    logic reset;

    int n_vec;
    int n_err;

    tag_free_list_mp_if #(.TAG_BITS(3), .NUM_REL(2)) bus ();

    tag_free_list_mp #(
        .TAG_BITS  (3),
        .NUM_REL   (2),
        .LOW_WATER (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_req = 1'b0;
        bus.rel_valid = 2'b00;
        bus.rel_tag   = '0;
        bus.flush     = 1'b0;
        bus.enable    = 1'b1;
    endtask

    task automatic release2(input logic [1:0] v, input logic [2:0] t1, input logic [2:0] t0);
        bus.rel_valid = v;
        bus.rel_tag   = {t1, t0};
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_state(input string name, input int cnt, input int tag, input int lw, input int err);
        check({name, ".free_count"}, 32'(bus.free_count), 32'(cnt));
        check({name, ".alloc_valid"}, 32'(bus.alloc_valid), 32'(cnt != 0));
        if (cnt != 0) check({name, ".alloc_tag"}, 32'(bus.alloc_tag), 32'(tag));
        check({name, ".low_water"}, 32'(bus.low_water), 32'(lw));
        check({name, ".err_double_free"}, 32'(bus.err_double_free), 32'(err));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state: full list, head tag 0.
        check_state("reset", 8, 0, 0, 0);

        // Drain with 8 back-to-back allocs; low_water once count <= 2.
        for (int i = 0; i < 8; i++) begin
            check("drain.tag", 32'(bus.alloc_tag), 32'(i));
            bus.alloc_req = 1'b1;
            tick();
            check("drain.count", 32'(bus.free_count), 32'(7 - i));
            check("drain.low_water", 32'(bus.low_water), 32'((7 - i) <= 2));
        end
        check("empty.alloc_valid", 32'(bus.alloc_valid), 32'(0));

        // Alloc while empty is ignored without error.
        tick();
        check_state("alloc_empty", 0, 0, 1, 0);
        idle();

        // Two releases in one cycle, returned in port order.
        release2(2'b11, 3'd2, 3'd5);
        tick();
        idle();
        check_state("rel_5_2", 2, 5, 1, 0);
        bus.alloc_req = 1'b1;
        tick();
        check_state("alloc_5", 1, 2, 1, 0);
        tick();
        idle();
        check_state("alloc_2", 0, 0, 1, 0);

        // Release tag 0 twice in consecutive cycles.
        release2(2'b01, 3'd0, 3'd0);
        tick();
        check_state("rel0_first", 1, 0, 1, 0);
        tick();
        idle();
        check_state("rel0_second", 1, 0, 1, 1);
        tick();
        check_state("err_clears", 1, 0, 1, 0);

        // Same tag on both ports in one cycle: one taken, one flagged.
        release2(2'b11, 3'd3, 3'd3);
        tick();
        idle();
        check_state("dup_3", 2, 0, 1, 1);
        bus.alloc_req = 1'b1;
        tick();
        idle();
        check_state("alloc_0_after_dup", 1, 3, 1, 0);

        // Flush with traffic in flight: the traffic is lost.
        bus.flush     = 1'b1;
        bus.alloc_req = 1'b1;
        release2(2'b01, 3'd0, 3'd7);
        tick();
        idle();
        check_state("flush", 8, 0, 0, 0);

        // Full list: alloc tag 0 and release tag 0 in the same cycle.
        bus.alloc_req = 1'b1;
        release2(2'b01, 3'd0, 3'd0);
        tick();
        idle();
        check_state("alloc_rel_same", 7, 1, 0, 1);
        tick();
        check_state("idle_after", 7, 1, 0, 0);

        // enable=0 freezes everything even with requests present.
        bus.enable    = 1'b0;
        bus.alloc_req = 1'b1;
        release2(2'b11, 3'd2, 3'd0);
        tick();
        tick();
        check_state("frozen", 7, 1, 0, 0);
        idle();

        // Two more allocs, then reset while enable=0.
        bus.alloc_req = 1'b1;
        tick();
        tick();
        idle();
        check_state("pre_reset", 5, 3, 0, 0);
        bus.enable = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check_state("reset_disabled", 8, 0, 0, 0);

        // Wrapped ring: drain 7 then release 6 and 4 back onto a near-empty list.
        bus.alloc_req = 1'b1;
        repeat (7) tick();
        idle();
        check_state("drain7", 1, 7, 1, 0);
        release2(2'b11, 3'd4, 3'd6);
        tick();
        idle();
        check_state("rel_wrap", 3, 7, 0, 0);
        bus.alloc_req = 1'b1;
        tick();
        check_state("wrap_a", 2, 6, 1, 0);
        tick();
        idle();
        check_state("wrap_b", 1, 4, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
